// File: rtl/aes_engine_stream_ctrl_pkg.sv
// Shared types and constants for the AES engine stream controller.
package aes_engine_stream_ctrl_pkg;

  localparam int unsigned DATA_WIDTH   = 32;
  localparam int unsigned BLOCK_WIDTH  = 128;
  localparam int unsigned CNT_WIDTH    = 16;
  localparam int unsigned STRB_WIDTH   = DATA_WIDTH / 8;
  localparam int unsigned AES_NB_WORDS = BLOCK_WIDTH / DATA_WIDTH;

  typedef enum logic [1:0] {
    EngIdle,
    EngLoad,
    EngCipher,
    EngDrain
  } aes_eng_state_t;

  typedef struct packed {
    logic clear;
    logic start;
    logic enable;
  } ctrl_engine_t;

  typedef struct packed {
    logic                 busy;
    logic                 done;
    logic [CNT_WIDTH-1:0] blk_cnt;
  } flags_engine_t;

  // Word 0 sits in the least significant bits of the block.
  function automatic logic [DATA_WIDTH-1:0] get_word(input logic [BLOCK_WIDTH-1:0] blk,
                                                     input logic [1:0]             idx);
    return blk[32'(idx) * DATA_WIDTH +: DATA_WIDTH];
  endfunction

endpackage

// File: rtl/aes_engine_stream_ctrl_word_buffer.sv
// 4x32 word register: indexed strobe-masked word writes or whole-block load.
module aes_engine_stream_ctrl_word_buffer
  import aes_engine_stream_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clr_i,
  input  logic                   we_i,
  input  logic [1:0]             widx_i,
  input  logic [DATA_WIDTH-1:0]  wdata_i,
  input  logic [STRB_WIDTH-1:0]  wstrb_i,
  input  logic                   load_i,
  input  logic [BLOCK_WIDTH-1:0] block_i,
  output logic [BLOCK_WIDTH-1:0] block_o
);

  logic [AES_NB_WORDS-1:0][DATA_WIDTH-1:0] words_q, words_d;
  logic [DATA_WIDTH-1:0]                   masked;

  always_comb begin
    masked = '0;
    for (int b = 0; b < int'(STRB_WIDTH); b++) begin
      masked[8*b +: 8] = wstrb_i[b] ? wdata_i[8*b +: 8] : 8'h00;
    end
  end

  always_comb begin
    words_d = words_q;
    if (clr_i) begin
      words_d = '0;
    end else if (load_i) begin
      words_d = block_i;
    end else if (we_i) begin
      words_d[widx_i] = masked;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      words_q <= '0;
    end else begin
      words_q <= words_d;
    end
  end

  assign block_o = words_q;

endmodule

// File: rtl/aes_engine_stream_ctrl.sv
// Engine-side controller: packs plaintext words into a block, runs the AES core,
// and serialises the ciphertext block back out as words.
module aes_engine_stream_ctrl
  import aes_engine_stream_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clear,
  input  ctrl_engine_t           ctrl_i,
  output flags_engine_t          flags_o,
  input  logic [CNT_WIDTH-1:0]   nb_blocks_i,
  input  logic [BLOCK_WIDTH-1:0] key_i,
  input  logic                   pt_valid_i,
  input  logic [DATA_WIDTH-1:0]  pt_data_i,
  input  logic [STRB_WIDTH-1:0]  pt_strb_i,
  output logic                   pt_ready_o,
  output logic                   ct_valid_o,
  output logic [DATA_WIDTH-1:0]  ct_data_o,
  output logic [STRB_WIDTH-1:0]  ct_strb_o,
  input  logic                   ct_ready_i,
  output logic                   core_start_o,
  output logic [BLOCK_WIDTH-1:0] core_block_o,
  output logic [BLOCK_WIDTH-1:0] core_key_o,
  input  logic                   core_done_i,
  input  logic [BLOCK_WIDTH-1:0] core_block_i
);

  aes_eng_state_t       state_q;
  logic [1:0]           w_cnt_q, o_cnt_q;
  logic [CNT_WIDTH-1:0] blk_cnt_q, nb_q, blk_nxt;
  logic                 start_pend_q, res_pend_q, done_q;
  logic                 clr_all, pt_hs, ct_hs, res_in;
  logic [BLOCK_WIDTH-1:0] ct_block;

  assign clr_all      = clear | ctrl_i.clear;
  assign pt_ready_o   = (state_q == EngLoad) & ctrl_i.enable & ~clr_all;
  assign pt_hs        = pt_ready_o & pt_valid_i;
  assign ct_valid_o   = (state_q == EngDrain) & ~clr_all;
  // While frozen the word stays presented but a sink handshake is not counted.
  assign ct_hs        = ct_valid_o & ct_ready_i & ctrl_i.enable;
  assign core_start_o = (state_q == EngCipher) & start_pend_q & ctrl_i.enable & ~clr_all;
  assign res_in       = (state_q == EngCipher) & core_done_i & ~clr_all;
  assign blk_nxt      = blk_cnt_q + 1'b1;

  assign ct_data_o       = get_word(ct_block, o_cnt_q);
  assign ct_strb_o       = {STRB_WIDTH{ct_valid_o}};
  assign core_key_o      = key_i;
  assign flags_o.busy    = (state_q != EngIdle);
  assign flags_o.done    = done_q;
  assign flags_o.blk_cnt = blk_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= EngIdle;
      w_cnt_q      <= '0;
      o_cnt_q      <= '0;
      blk_cnt_q    <= '0;
      nb_q         <= '0;
      start_pend_q <= 1'b0;
      res_pend_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (clr_all) begin
        state_q      <= EngIdle;
        w_cnt_q      <= '0;
        o_cnt_q      <= '0;
        blk_cnt_q    <= '0;
        nb_q         <= '0;
        start_pend_q <= 1'b0;
        res_pend_q   <= 1'b0;
      end else begin
        unique case (state_q)
          EngIdle: begin
            if (ctrl_i.start) begin
              state_q   <= EngLoad;
              nb_q      <= (nb_blocks_i == '0) ? CNT_WIDTH'(1) : nb_blocks_i;
              blk_cnt_q <= '0;
              w_cnt_q   <= '0;
            end
          end
          EngLoad: begin
            if (pt_hs) begin
              w_cnt_q <= w_cnt_q + 2'd1;
              if (w_cnt_q == 2'd3) begin
                state_q      <= EngCipher;
                start_pend_q <= 1'b1;
                res_pend_q   <= 1'b0;
              end
            end
          end
          EngCipher: begin
            if (core_start_o) start_pend_q <= 1'b0;
            // A result arriving while frozen is remembered until enable returns.
            if (core_done_i) res_pend_q <= 1'b1;
            if (ctrl_i.enable && (core_done_i || res_pend_q)) begin
              state_q    <= EngDrain;
              o_cnt_q    <= '0;
              res_pend_q <= 1'b0;
            end
          end
          EngDrain: begin
            if (ct_hs) begin
              o_cnt_q <= o_cnt_q + 2'd1;
              if (o_cnt_q == 2'd3) begin
                blk_cnt_q <= blk_nxt;
                if (blk_nxt == nb_q) begin
                  state_q <= EngIdle;
                  done_q  <= 1'b1;
                end else begin
                  state_q <= EngLoad;
                  w_cnt_q <= '0;
                end
              end
            end
          end
          default: state_q <= EngIdle;
        endcase
      end
    end
  end

  aes_engine_stream_ctrl_word_buffer u_in_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (clr_all),
    .we_i    (pt_hs),
    .widx_i  (w_cnt_q),
    .wdata_i (pt_data_i),
    .wstrb_i (pt_strb_i),
    .load_i  (1'b0),
    .block_i ('0),
    .block_o (core_block_o)
  );

  aes_engine_stream_ctrl_word_buffer u_out_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (clr_all),
    .we_i    (1'b0),
    .widx_i  (2'd0),
    .wdata_i ('0),
    .wstrb_i ('0),
    .load_i  (res_in),
    .block_i (core_block_i),
    .block_o (ct_block)
  );

endmodule
